// File: rtl/mdio_cmd_seq.sv
// rtl/mdio_cmd_seq.sv - MDIO host command sequencer: request/response front end for the MDIO bit-level master
//
// Builds a 32-bit clause-22 frame from a host request, issues it to the MDIO
// master with a one-cycle start pulse, waits for a completion flag or a timeout,
// and returns exactly one response per request.
//
// Optional feature macro: MDIO_LINK_POLL_EN (autonomous BMSR link polling).
//
// Ports:
//   i_clk, i_reset                 clock, asynchronous active-high reset
//   i_req_valid / o_req_ready      request handshake (ready only in IDLE)
//   i_req_write, i_req_phy,
//   i_req_reg, i_req_wdata         request fields, sampled at handshake
//   o_resp_valid / i_resp_ready    response handshake, held until accepted
//   o_resp_rdata, o_resp_err       read data (MSB-correct) and timeout flag
//   o_new_cmd, o_cmd               start pulse and frame to the MDIO master
//   i_data_written_flag,
//   i_data_read_flag, i_mdio_rdata completion pulses and wire-order read data
//   o_link_up                      last polled BMSR link bit (0 without the macro)
module mdio_cmd_seq #(
    parameter int TIMEOUT_CYC = 64
`ifdef MDIO_LINK_POLL_EN
    ,
    parameter int POLL_INTERVAL = 100000,
    parameter int POLL_PHY = 0
`endif
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [4:0]  i_req_phy,
    input  logic [4:0]  i_req_reg,
    input  logic [15:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [15:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_new_cmd,
    output logic [31:0] o_cmd,
    input  logic        i_data_written_flag,
    input  logic        i_data_read_flag,
    input  logic [15:0] i_mdio_rdata,
    output logic        o_link_up
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q;
    logic [31:0]     cmd_q;
    logic [15:0]     rdata_q;
    logic            err_q;
    logic            accept;
    logic            expire;
    logic            flag_any;

    // Frame bit i goes on the wire i-th, so multi-bit fields are stored reversed.
    function automatic logic [31:0] build_frame(input logic wr, input logic [4:0] phy,
                                                input logic [4:0] ra, input logic [15:0] wd);
        logic [31:0] f;
        f = '0;
        f[1:0]   = 2'b10;
        f[3:2]   = wr ? 2'b10 : 2'b01;
        for (int i = 0; i < 5; i++) begin
            f[4 + i] = phy[4 - i];
            f[9 + i] = ra[4 - i];
        end
        f[15:14] = wr ? 2'b01 : 2'b00;
        for (int i = 0; i < 16; i++) begin
            f[16 + i] = wr ? wd[15 - i] : 1'b0;
        end
        return f;
    endfunction

    function automatic logic [15:0] rev16(input logic [15:0] d);
        logic [15:0] r;
        for (int k = 0; k < 16; k++) begin
            r[k] = d[15 - k];
        end
        return r;
    endfunction

    // Timer holds the number of cycles since o_new_cmd while in WAIT.
    assign expire   = (timer_q == TW'(TIMEOUT_CYC - 1));
    assign flag_any = i_data_written_flag | i_data_read_flag;

`ifdef MDIO_LINK_POLL_EN
    localparam int IW = $clog2(POLL_INTERVAL + 1);
    logic          poll_q;
    logic          poll_start;
    logic          link_q;
    logic [IW-1:0] idle_cnt_q;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
`ifdef MDIO_LINK_POLL_EN
        poll_start = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // A host request always wins over a poll trigger in the same cycle.
                if (i_req_valid) begin
                    accept  = 1'b1;
                    state_d = S_ISSUE;
                end
`ifdef MDIO_LINK_POLL_EN
                else if (idle_cnt_q == IW'(POLL_INTERVAL - 1)) begin
                    poll_start = 1'b1;
                    state_d    = S_ISSUE;
                end
`endif
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (flag_any || expire) begin
`ifdef MDIO_LINK_POLL_EN
                    state_d = poll_q ? S_IDLE : S_RESP;
`else
                    state_d = S_RESP;
`endif
                end
            end
            S_RESP: begin
                if (i_resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            timer_q <= '0;
            cmd_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef MDIO_LINK_POLL_EN
            poll_q     <= 1'b0;
            link_q     <= 1'b0;
            idle_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    timer_q <= '0;
                    if (accept) begin
                        cmd_q <= build_frame(i_req_write, i_req_phy, i_req_reg, i_req_wdata);
`ifdef MDIO_LINK_POLL_EN
                        poll_q <= 1'b0;
                    end else if (poll_start) begin
                        cmd_q  <= build_frame(1'b0, 5'(POLL_PHY), 5'd1, 16'd0);
                        poll_q <= 1'b1;
`endif
                    end
                end
                S_ISSUE: timer_q <= TW'(1);
                S_WAIT: begin
                    timer_q <= timer_q + TW'(1);
`ifdef MDIO_LINK_POLL_EN
                    if (poll_q) begin
                        if (i_data_read_flag) begin
                            link_q <= i_mdio_rdata[13];
                        end else if (!i_data_written_flag && expire) begin
                            link_q <= 1'b0;
                        end
                    end else
`endif
                    // A flag in the expiry cycle takes priority, so it counts as success.
                    if (i_data_read_flag) begin
                        rdata_q <= rev16(i_mdio_rdata);
                        err_q   <= 1'b0;
                    end else if (i_data_written_flag) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end else if (expire) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
`ifdef MDIO_LINK_POLL_EN
            // Counter restarts after any transaction and whenever the host is asking.
            if (state_q == S_IDLE && !i_req_valid) begin
                idle_cnt_q <= idle_cnt_q + IW'(1);
            end else begin
                idle_cnt_q <= '0;
            end
`endif
        end
    end

    assign o_req_ready  = (state_q == S_IDLE);
    assign o_new_cmd    = (state_q == S_ISSUE);
    assign o_resp_valid = (state_q == S_RESP);
    assign o_cmd        = cmd_q;
    assign o_resp_rdata = rdata_q;
    assign o_resp_err   = err_q;
`ifdef MDIO_LINK_POLL_EN
    assign o_link_up    = link_q;
`else
    assign o_link_up    = 1'b0;
`endif

endmodule
